// File: rtl/instruction_decode_fsm.sv
// Decode front end: fetch from a synchronous ROM, read both source rows from data RAM,
// forward in-flight write-backs into the operands, then issue a one-cycle decode strobe.
module instruction_decode_fsm #(
  parameter int              OP_W      = 16,
  parameter int              ADDR_W    = 16,
  parameter int              IP_W      = 16,
  parameter int              DATA_W    = 96,
  parameter logic [OP_W-1:0] RETURN_OP = {OP_W{1'b0}},
  parameter int              INST_W    = OP_W + 3*ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iStart,
  input  logic [IP_W-1:0]   iInitialIP,
  output logic [IP_W-1:0]   oROMAddress,
  input  logic [INST_W-1:0] iInstruction,
  output logic [ADDR_W-1:0] oRAMReadAddress0,
  output logic [ADDR_W-1:0] oRAMReadAddress1,
  input  logic [DATA_W-1:0] iRAMReadData0,
  input  logic [DATA_W-1:0] iRAMReadData1,
  input  logic              iRAMWriteEnable,
  input  logic [ADDR_W-1:0] iRAMWriteAddress,
  input  logic [DATA_W-1:0] iRAMWriteData,
  input  logic              iExeBusy,
  input  logic              iJumpFlag,
  input  logic [IP_W-1:0]   iJumpIp,
  output logic              oDecodeDone,
  output logic [OP_W-1:0]   oOperation,
  output logic [DATA_W-1:0] oSource0,
  output logic [DATA_W-1:0] oSource1,
  output logic [ADDR_W-1:0] oDestination,
  output logic [IP_W-1:0]   oCurrentIP,
  output logic              oProgramDone
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_READ, S_WAIT, S_ISSUE} state_t;

  state_t              state_q, state_d;
  logic [IP_W-1:0]     ip_q, ip_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ADDR_W-1:0]   dest_q, dest_d, src0_q, src0_d, src1_q, src1_d;
  logic [DATA_W-1:0]   opnd0_q, opnd0_d, opnd1_q, opnd1_d, pend_dat_q, pend_dat_d;
  logic                pend0_q, pend0_d, pend1_q, pend1_d, first_q, first_d, pdone_q, pdone_d;
  logic [OP_W-1:0]     out_op_q, out_op_d;
  logic [ADDR_W-1:0]   out_dest_q, out_dest_d;
  logic [DATA_W-1:0]   out_s0_q, out_s0_d, out_s1_q, out_s1_d;
  logic [IP_W-1:0]     out_ip_q, out_ip_d;

  logic [OP_W-1:0]     inst_op;
  logic [ADDR_W-1:0]   inst_dest, inst_src1, inst_src0;
  logic                hit0, hit1;

  assign inst_op   = iInstruction[INST_W-1 -: OP_W];
  assign inst_dest = iInstruction[3*ADDR_W-1 -: ADDR_W];
  assign inst_src1 = iInstruction[2*ADDR_W-1 -: ADDR_W];
  assign inst_src0 = iInstruction[ADDR_W-1:0];

  // During READ the RAM is addressed straight from the ROM word; afterwards from the latched copy.
  assign oRAMReadAddress0 = (state_q == S_READ) ? inst_src0 : src0_q;
  assign oRAMReadAddress1 = (state_q == S_READ) ? inst_src1 : src1_q;
  assign hit0 = iRAMWriteEnable && (iRAMWriteAddress == oRAMReadAddress0);
  assign hit1 = iRAMWriteEnable && (iRAMWriteAddress == oRAMReadAddress1);

  assign oROMAddress  = ip_q;
  assign oDecodeDone  = (state_q == S_ISSUE);
  assign oProgramDone = pdone_q;
  assign oOperation   = out_op_q;
  assign oDestination = out_dest_q;
  assign oSource0     = out_s0_q;
  assign oSource1     = out_s1_q;
  assign oCurrentIP   = out_ip_q;

  always_comb begin
    state_d    = state_q;
    ip_d       = ip_q;
    op_d       = op_q;
    dest_d     = dest_q;
    src0_d     = src0_q;
    src1_d     = src1_q;
    opnd0_d    = opnd0_q;
    opnd1_d    = opnd1_q;
    pend0_d    = pend0_q;
    pend1_d    = pend1_q;
    pend_dat_d = pend_dat_q;
    first_d    = first_q;
    pdone_d    = 1'b0;
    out_op_d   = out_op_q;
    out_dest_d = out_dest_q;
    out_s0_d   = out_s0_q;
    out_s1_d   = out_s1_q;
    out_ip_d   = out_ip_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          ip_d    = iInitialIP;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_READ;
        if (iJumpFlag) begin
          ip_d    = iJumpIp;
          state_d = S_FETCH;
        end
      end
      S_READ: begin
        if (iJumpFlag) begin
          ip_d    = iJumpIp;
          state_d = S_FETCH;
        end else begin
          op_d       = inst_op;
          dest_d     = inst_dest;
          src0_d     = inst_src0;
          src1_d     = inst_src1;
          // RAM returns pre-write contents next cycle, so remember this write to overlay it.
          pend0_d    = hit0;
          pend1_d    = hit1;
          pend_dat_d = iRAMWriteData;
          first_d    = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        first_d = 1'b0;
        if (iJumpFlag) begin
          ip_d    = iJumpIp;
          state_d = S_FETCH;
        end else begin
          if (first_q) begin
            opnd0_d = pend0_q ? pend_dat_q : iRAMReadData0;
            opnd1_d = pend1_q ? pend_dat_q : iRAMReadData1;
          end
          if (hit0) opnd0_d = iRAMWriteData;
          if (hit1) opnd1_d = iRAMWriteData;
          if (!iExeBusy && !iRAMWriteEnable) begin
            state_d    = S_ISSUE;
            out_op_d   = op_q;
            out_dest_d = dest_q;
            out_s0_d   = opnd0_d;
            out_s1_d   = opnd1_d;
            out_ip_d   = ip_q;
          end
        end
      end
      S_ISSUE: begin
        if (out_op_q == RETURN_OP) begin
          pdone_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          ip_d    = iJumpFlag ? iJumpIp : ip_q + IP_W'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      ip_q       <= '0;
      op_q       <= '0;
      dest_q     <= '0;
      src0_q     <= '0;
      src1_q     <= '0;
      opnd0_q    <= '0;
      opnd1_q    <= '0;
      pend0_q    <= 1'b0;
      pend1_q    <= 1'b0;
      pend_dat_q <= '0;
      first_q    <= 1'b0;
      pdone_q    <= 1'b0;
      out_op_q   <= '0;
      out_dest_q <= '0;
      out_s0_q   <= '0;
      out_s1_q   <= '0;
      out_ip_q   <= '0;
    end else begin
      state_q    <= state_d;
      ip_q       <= ip_d;
      op_q       <= op_d;
      dest_q     <= dest_d;
      src0_q     <= src0_d;
      src1_q     <= src1_d;
      opnd0_q    <= opnd0_d;
      opnd1_q    <= opnd1_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
      pend_dat_q <= pend_dat_d;
      first_q    <= first_d;
      pdone_q    <= pdone_d;
      out_op_q   <= out_op_d;
      out_dest_q <= out_dest_d;
      out_s0_q   <= out_s0_d;
      out_s1_q   <= out_s1_d;
      out_ip_q   <= out_ip_d;
    end
  end

endmodule

// File: doc/instruction_decode_fsm.md
Name: instruction_decode_fsm

Overview:
- Front-end stage directly upstream of the execution FSM.
- Fetches instruction words from the code ROM, decodes the opcode, destination and two source addresses, and reads both source rows from data RAM.
- Forwards pending write-backs from the execution stage into those operands, then issues a one-cycle decode-done pulse carrying operation, sources and destination.
- Handles jump redirects and program start/stop.

Parameters:
- OP_W, 16, opcode width (matches INSTRUCTION_OP_LENGTH).
- ADDR_W, 16, data RAM address width (matches DATA_ADDRESS_WIDTH).
- IP_W, 16, ROM address width (matches ROM_ADDRESS_WIDTH).
- DATA_W, 96, data row width (three 32-bit channels).
- RETURN_OP, 16'd0, opcode that ends the program.
- INST_W, OP_W+3*ADDR_W, instruction word width (derived).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- iStart  in  1  one-cycle pulse; start fetching at iInitialIP.
- iInitialIP  in  IP_W  program entry address.
- oROMAddress  out  IP_W  instruction fetch address. ROM is synchronous: data is valid 1 cycle later.
- iInstruction  in  INST_W  {op, dest, src1, src0}, MSB first.
- oRAMReadAddress0  out  ADDR_W  source0 read address.
- oRAMReadAddress1  out  ADDR_W  source1 read address.
- iRAMReadData0  in  DATA_W  source0 data, 1-cycle latency, returns pre-write contents.
- iRAMReadData1  in  DATA_W  source1 data, same timing as iRAMReadData0.
- iRAMWriteEnable  in  1  execution-stage write-back strobe.
- iRAMWriteAddress  in  ADDR_W  write-back address.
- iRAMWriteData  in  DATA_W  write-back data.
- iExeBusy  in  1  execution stage busy.
- iJumpFlag  in  1  branch taken.
- iJumpIp  in  IP_W  branch target.
- oDecodeDone  out  1  issue strobe.
- oOperation  out  OP_W  decoded opcode.
- oSource0  out  DATA_W  source0 row, after forwarding.
- oSource1  out  DATA_W  source1 row, after forwarding.
- oDestination  out  ADDR_W  destination address.
- oCurrentIP  out  IP_W  IP of the instruction being decoded.
- oProgramDone  out  1  one-cycle pulse after RETURN_OP issues.

Behaviour:
- Reset values: state IDLE; IP=0; all outputs 0; oDecodeDone=0; oProgramDone=0.
- States:
  - IDLE: if iStart, IP<=iInitialIP and go FETCH.
  - FETCH: oROMAddress=IP; go READ.
  - READ: latch iInstruction into op/dest/src registers; drive read addresses from iInstruction combinationally; go WAIT.
  - WAIT: first WAIT cycle latches iRAMReadData0/1 into the operand registers. Stay while iExeBusy=1. Leave when iExeBusy=0 and no write occurs this cycle, going to ISSUE.
  - ISSUE: oDecodeDone=1 for exactly one cycle, outputs stable. If op==RETURN_OP, pulse oProgramDone next cycle and go IDLE; else IP<=IP+1 (wraps modulo 2^IP_W) and go FETCH.
- Forwarding:
  - Applies to any cycle in READ or WAIT where iRAMWriteEnable=1 and iRAMWriteAddress equals a source address.
  - The matching operand register takes iRAMWriteData.
  - A write in the READ cycle is held in a pending register and applied over the RAM data on the first WAIT cycle.
  - A write in the same cycle as data capture takes priority over RAM data.
  - src0==src1 with a match updates both operands.
- Jump:
  - iJumpFlag=1 in FETCH, READ or WAIT: discard the in-flight instruction, IP<=iJumpIp, go FETCH next cycle.
  - iJumpFlag takes priority over the WAIT exit and over forwarding.
  - Ignored in IDLE.
  - In ISSUE, the jump wins over IP+1.
- Outputs hold their last issued values between strobes.
- iStart outside IDLE is ignored.
- Reset mid-operation returns to IDLE immediately; no oDecodeDone is emitted.
- Minimum issue-to-issue spacing is 4 cycles (ISSUE, FETCH, READ, WAIT).

Test Plan:
1. Reset, then iStart with iInitialIP=5 → oROMAddress=5 the next cycle; oDecodeDone at cycle 4 with oCurrentIP=5; next fetch at 6.
2. Instruction {op=3, dest=0x10, src1=0x20, src0=0x21}, RAM[0x20]=A, RAM[0x21]=B, iExeBusy=0 → oOperation=3, oDestination=0x10, oSource1=A, oSource0=B, oDecodeDone high exactly 1 cycle.
3. iExeBusy=1 for 6 cycles; write to 0x20 with data C on cycle 5 → issue waits until iExeBusy=0; oSource1=C, oSource0 unchanged.
4. Write to src0 address during the READ cycle → oSource0 equals the write data, not the stale RAM value.
5. iJumpFlag=1 with iJumpIp=0x40 during WAIT → no issue of the current instruction; oROMAddress=0x40 on the next cycle.
6. RETURN_OP fetched → single oDecodeDone, then oProgramDone pulse; stays IDLE until the next iStart. Reset asserted in WAIT → all outputs return to 0.
